// File: rtl/pad_sched_pkg.sv
// Shared types and constants for the pad-to-player-slot scheduler.
package pad_sched_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        REMAP  = 2'd1,
        RUN    = 2'd2
    } sched_state_t;

    localparam int BTN_SELECT = 14;
    localparam int BTN_START  = 15;
    localparam int NUM_PADS   = 4;

    typedef logic [1:0] pad_idx_t;

endpackage

// File: rtl/coin_pulse.sv
// Select rising edge -> fixed COIN_MS-long coin pulse; one cycle from edge to pulse.
// No backpressure: retriggers during an active pulse are dropped, never queued.
module coin_pulse #(
    parameter int COIN_MS = 100
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic tick_ms,
    input  logic trig_en,
    input  logic sel,
    output logic pulse
);

    logic       sel_q;
    logic [7:0] cnt_q;

    // sel_q follows sel every cycle; the top steers sel to the new source
    // during REMAP so a Select already held there is not seen as an edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sel_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            sel_q <= sel;
            if (trig_en && sel && !sel_q && (cnt_q == 8'd0)) begin
                cnt_q <= 8'(COIN_MS);
            end else if (tick_ms && (cnt_q != 8'd0)) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign pulse = (cnt_q != 8'd0);

endmodule

// File: rtl/pad_slot_scheduler.sv
// Debounced hot-plug assignment of up to four pads to P1/P2; joy words are 1-cycle registered.
// No backpressure: outputs are forced to zero while settling or remapping.
module pad_slot_scheduler
    import pad_sched_pkg::*;
#(
    parameter int DEBOUNCE_MS = 50,
    parameter int COIN_MS     = 100
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         tick_ms,
    input  logic [NUM_PADS-1:0][15:0]    pad_joy,
    input  logic [NUM_PADS-1:0][3:0]     pad_type,
    output logic [15:0]                  p1_joy,
    output logic [15:0]                  p2_joy,
    output pad_idx_t                     p1_src,
    output pad_idx_t                     p2_src,
    output logic                         p1_vld,
    output logic                         p2_vld,
    output logic [1:0]                   coin,
    output logic                         busy
);

    sched_state_t          state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_PADS-1:0]   present, present_q;
    pad_idx_t              p1_src_q, p2_src_q, p1_find, p2_find;
    logic                  p1_vld_q, p2_vld_q, p1_hit, p2_hit;
    logic [15:0]           p1_joy_q, p2_joy_q;
    logic                  run_hold, p1_sel, p2_sel;

    always_comb begin
        present = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            present[i] = (pad_type[i] != 4'd0);
        end
    end

    always_comb begin
        p1_find = '0;
        p2_find = '0;
        p1_hit  = 1'b0;
        p2_hit  = 1'b0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (present_q[i]) begin
                if (!p1_hit) begin
                    p1_hit  = 1'b1;
                    p1_find = pad_idx_t'(i);
                end else if (!p2_hit) begin
                    p2_hit  = 1'b1;
                    p2_find = pad_idx_t'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SETTLE: begin
                if (present != present_q) begin
                    cnt_d = 8'd0;
                end else if (tick_ms) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == 8'(DEBOUNCE_MS)) begin
                        state_d = REMAP;
                    end
                end
            end
            REMAP: begin
                cnt_d   = 8'd0;
                state_d = RUN;
            end
            RUN: begin
                if (present != present_q) begin
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = SETTLE;
            end
        endcase
    end

    // Joy words pass only when both this and the next cycle are RUN, so they
    // drop to zero the same cycle busy rises.
    assign run_hold = (state_q == RUN) && (state_d == RUN);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= SETTLE;
            cnt_q     <= 8'd0;
            present_q <= '0;
            p1_src_q  <= '0;
            p2_src_q  <= '0;
            p1_vld_q  <= 1'b0;
            p2_vld_q  <= 1'b0;
            p1_joy_q  <= '0;
            p2_joy_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            present_q <= present;
            if (state_q == REMAP) begin
                p1_src_q <= p1_find;
                p2_src_q <= p2_find;
                p1_vld_q <= p1_hit;
                p2_vld_q <= p2_hit;
            end
            p1_joy_q <= (run_hold && p1_vld_q) ? pad_joy[p1_src_q] : 16'd0;
            p2_joy_q <= (run_hold && p2_vld_q) ? pad_joy[p2_src_q] : 16'd0;
        end
    end

    assign p1_sel = (state_q == REMAP) ? pad_joy[p1_find][BTN_SELECT] : pad_joy[p1_src_q][BTN_SELECT];
    assign p2_sel = (state_q == REMAP) ? pad_joy[p2_find][BTN_SELECT] : pad_joy[p2_src_q][BTN_SELECT];

    coin_pulse #(.COIN_MS(COIN_MS)) u_coin_p1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick_ms (tick_ms),
        .trig_en ((state_q == RUN) && p1_vld_q),
        .sel     (p1_sel),
        .pulse   (coin[0])
    );

    coin_pulse #(.COIN_MS(COIN_MS)) u_coin_p2 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick_ms (tick_ms),
        .trig_en ((state_q == RUN) && p2_vld_q),
        .sel     (p2_sel),
        .pulse   (coin[1])
    );

    assign p1_joy = p1_joy_q;
    assign p2_joy = p2_joy_q;
    assign p1_src = p1_src_q;
    assign p2_src = p2_src_q;
    assign p1_vld = p1_vld_q;
    assign p2_vld = p2_vld_q;
    assign busy   = (state_q != RUN);

endmodule

// File: tb/tb_pad_slot_scheduler.sv
// Directed bench for pad_slot_scheduler with DEBOUNCE_MS = 4, COIN_MS = 3.
module tb_pad_slot_scheduler;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              tick_ms;
    logic [3:0][15:0]  pad_joy;
    logic [3:0][3:0]   pad_type;
    logic [15:0]       p1_joy, p2_joy;
    logic [1:0]        p1_src, p2_src;
    logic              p1_vld, p2_vld;
    logic [1:0]        coin;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    pad_slot_scheduler #(.DEBOUNCE_MS(4), .COIN_MS(3)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .tick_ms  (tick_ms),
        .pad_joy  (pad_joy),
        .pad_type (pad_type),
        .p1_joy   (p1_joy),
        .p2_joy   (p2_joy),
        .p1_src   (p1_src),
        .p2_src   (p2_src),
        .p1_vld   (p1_vld),
        .p2_vld   (p2_vld),
        .coin     (coin),
        .busy     (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock with the current inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic t);
        tick_ms = t;
        @(posedge clk_sys);
        #1;
        tick_ms = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        tick_ms  = 1'b0;
        pad_joy  = '0;
        pad_type = '0;
        cyc(1'b0);
        cyc(1'b0);
        chk("rst_busy", 16'(busy), 16'd1);
        chk("rst_vld", {14'd0, p2_vld, p1_vld}, 16'd0);
        chk("rst_coin", 16'(coin), 16'd0);
        chk("rst_joy", p1_joy | p2_joy, 16'd0);
        chk("rst_src", {12'd0, p2_src, p1_src}, 16'd0);
        reset = 1'b0;

        // pads 0 and 2 connected
        pad_type[0] = 4'd1;
        pad_type[2] = 4'd3;
        pad_joy[0]  = 16'h0102;
        pad_joy[2]  = 16'h0011;
        cyc(1'b0);
        ticks(3);
        chk("deb_busy3", 16'(busy), 16'd1);
        cyc(1'b1);
        cyc(1'b0);
        chk("map_busy", 16'(busy), 16'd0);
        chk("map_p1src", 16'(p1_src), 16'd0);
        chk("map_p2src", 16'(p2_src), 16'd2);
        chk("map_vld", {14'd0, p2_vld, p1_vld}, 16'd3);
        chk("map_p2joy_lat", p2_joy, 16'h0000);
        cyc(1'b0);
        chk("run_p2joy", p2_joy, 16'h0011);
        chk("run_p1joy", p1_joy, 16'h0102);

        // unplug pad 0, with a glitch after two ticks
        pad_type[0] = 4'd0;
        cyc(1'b0);
        chk("unplug_busy", 16'(busy), 16'd1);
        chk("unplug_joy", p1_joy | p2_joy, 16'd0);
        chk("unplug_hold_vld", {14'd0, p2_vld, p1_vld}, 16'd3);
        ticks(2);
        pad_type[0] = 4'd1;
        cyc(1'b0);
        pad_type[0] = 4'd0;
        cyc(1'b0);
        ticks(3);
        chk("glitch_restart", 16'(busy), 16'd1);
        cyc(1'b1);
        cyc(1'b0);
        chk("remap1_busy", 16'(busy), 16'd0);
        chk("remap1_p1src", 16'(p1_src), 16'd2);
        chk("remap1_vld", {14'd0, p2_vld, p1_vld}, 16'd1);
        chk("remap1_p2src", 16'(p2_src), 16'd0);
        cyc(1'b0);
        chk("remap1_p1joy", p1_joy, 16'h0011);
        chk("remap1_p2joy", p2_joy, 16'h0000);

        // coin on P1: exactly 3 ticks, retrigger ignored
        pad_joy[2] = 16'h4011;
        cyc(1'b0);
        chk("coin_start", 16'(coin), 16'd1);
        cyc(1'b1);
        pad_joy[2] = 16'h0011;
        cyc(1'b0);
        pad_joy[2] = 16'h4011;
        cyc(1'b1);
        chk("coin_tick2", 16'(coin), 16'd1);
        cyc(1'b1);
        chk("coin_no_ext", 16'(coin), 16'd0);

        // Select held through REMAP on both new sources
        pad_type[3] = 4'd2;
        pad_joy[3]  = 16'h4000;
        cyc(1'b0);
        ticks(4);
        cyc(1'b0);
        chk("held_busy", 16'(busy), 16'd0);
        chk("held_p2src", 16'(p2_src), 16'd3);
        chk("held_coin_a", 16'(coin), 16'd0);
        cyc(1'b0);
        chk("held_coin_b", 16'(coin), 16'd0);
        chk("held_p2joy", p2_joy, 16'h4000);
        pad_joy[2] = 16'h0011;
        cyc(1'b0);
        pad_joy[2] = 16'h4011;
        cyc(1'b0);
        chk("repress_coin", 16'(coin), 16'd1);

        // leave RUN mid-pulse; tick coincident with a presence change
        pad_type[1] = 4'd5;
        cyc(1'b0);
        chk("settle_busy", 16'(busy), 16'd1);
        chk("pulse_continues", 16'(coin), 16'd1);
        ticks(2);
        chk("pulse_tick2", 16'(coin), 16'd1);
        pad_type[1] = 4'd0;
        cyc(1'b1);
        chk("pulse_done", 16'(coin), 16'd0);
        ticks(3);
        chk("tick_vs_change", 16'(busy), 16'd1);
        cyc(1'b1);
        cyc(1'b0);
        chk("remap2_busy", 16'(busy), 16'd0);
        chk("remap2_src", {12'd0, p2_src, p1_src}, 16'b1110);

        // reset mid-coin in RUN
        pad_joy[2] = 16'h0011;
        cyc(1'b0);
        pad_joy[2] = 16'h4011;
        cyc(1'b0);
        chk("coin_pre_rst", 16'(coin), 16'd1);
        reset = 1'b1;
        cyc(1'b0);
        chk("mrst_coin", 16'(coin), 16'd0);
        chk("mrst_busy", 16'(busy), 16'd1);
        chk("mrst_joy", p1_joy | p2_joy, 16'd0);
        chk("mrst_vld", {14'd0, p2_vld, p1_vld}, 16'd0);
        chk("mrst_src", {12'd0, p2_src, p1_src}, 16'd0);
        reset = 1'b0;

        // no pads connected
        pad_type   = '0;
        pad_joy[2] = 16'h0011;
        ticks(4);
        cyc(1'b0);
        chk("none_busy", 16'(busy), 16'd0);
        chk("none_vld", {14'd0, p2_vld, p1_vld}, 16'd0);
        cyc(1'b0);
        chk("none_joy", p1_joy | p2_joy, 16'd0);
        pad_joy[0] = 16'h4000;
        cyc(1'b0);
        cyc(1'b0);
        chk("none_coin", 16'(coin), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
